// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl : Moore control FSM for a multicycle RV32 core that shares
//                   one memory and one ALU (lw, sw, R, I, beq, jal).
//                   Optional build macro: MULTICYCLE_ILLEGAL_TRAP_EN
// Revision        : 1.0
// ============================================================================
module multicycle_ctrl #(
    parameter int FETCH_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal_op
);

    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_BEQ  = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;
    localparam logic [2:0] c_FETCH_LAST = 3'(FETCH_WAIT);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t     r_state;
    logic [2:0] r_cnt;
    logic       w_fetch_last;
    logic       w_pc_update;
    logic       w_branch;

    assign w_fetch_last = (r_cnt == c_FETCH_LAST);

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic r_illegal;
    assign illegal_op = r_illegal;
`else
    assign illegal_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= 3'd0;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_fetch_last) begin
                        r_cnt   <= 3'd0;
                        r_state <= S_DECODE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_DECODE: begin
                    case (op)
                        c_OP_LW, c_OP_SW: r_state <= S_MEMADR;
                        c_OP_R:           r_state <= S_EXECR;
                        c_OP_I:           r_state <= S_EXECI;
                        c_OP_BEQ:         r_state <= S_BEQ;
                        c_OP_JAL:         r_state <= S_JAL;
                        default: begin
                            r_state <= S_TRAP;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                            r_illegal <= 1'b1;
`endif
                        end
                    endcase
                end
                S_MEMADR:  r_state <= (op == c_OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD: r_state <= S_MEMWB;
                S_EXECR, S_EXECI, S_JAL: r_state <= S_ALUWB;
                S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: r_state <= S_FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                S_TRAP:    r_state <= S_TRAP;
`else
                S_TRAP:    r_state <= S_FETCH;
`endif
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    // Reset forces every enable and select low, including mid-instruction aborts.
    always_comb begin
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_op      = 2'b00;
        instr_done  = 1'b0;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    alu_src_b   = 2'b10;
                    result_src  = 2'b10;
                    ir_write    = w_fetch_last;
                    w_pc_update = w_fetch_last;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_MEMREAD: adr_src = 1'b1;
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWRITE: begin
                    adr_src    = 1'b1;
                    mem_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_EXECR: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b10;
                end
                S_EXECI: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b10;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a  = 2'b10;
                    alu_op     = 2'b01;
                    w_branch   = 1'b1;
                    instr_done = 1'b1;
                end
                S_JAL: begin
                    alu_src_a   = 2'b01;
                    alu_src_b   = 2'b10;
                    w_pc_update = 1'b1;
                end
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
                S_TRAP: instr_done = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign pc_write = !reset && (w_pc_update || (w_branch && zero));

    always_comb begin
        imm_src = 2'b00;
        if (!reset) begin
            case (op)
                c_OP_SW:  imm_src = 2'b01;
                c_OP_BEQ: imm_src = 2'b10;
                c_OP_JAL: imm_src = 2'b11;
                default:  imm_src = 2'b00;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// tb_multicycle_ctrl : self-checking bench, instruction table + per-cycle model
// Revision           : 1.0
// ============================================================================
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    localparam int NOPS = 6;
`else
    localparam int NOPS = 7;
`endif

    logic       clk = 1'b0;
    logic       rst0, rst1, z0, z1;
    logic [6:0] op0, op1;
    // {pc_write, adr_src, ir_write, mem_write, reg_write, src_a, src_b, result, imm, alu_op, done, illegal}
    wire [16:0] ow0, ow1;

    always #5 clk = ~clk;

    multicycle_ctrl #(.FETCH_WAIT(0)) u_dut0 (
        .clk(clk), .reset(rst0), .op(op0), .zero(z0),
        .pc_write(ow0[16]), .adr_src(ow0[15]), .ir_write(ow0[14]), .mem_write(ow0[13]),
        .reg_write(ow0[12]), .alu_src_a(ow0[11:10]), .alu_src_b(ow0[9:8]),
        .result_src(ow0[7:6]), .imm_src(ow0[5:4]), .alu_op(ow0[3:2]),
        .instr_done(ow0[1]), .illegal_op(ow0[0])
    );

    multicycle_ctrl #(.FETCH_WAIT(3)) u_dut1 (
        .clk(clk), .reset(rst1), .op(op1), .zero(z1),
        .pc_write(ow1[16]), .adr_src(ow1[15]), .ir_write(ow1[14]), .mem_write(ow1[13]),
        .reg_write(ow1[12]), .alu_src_a(ow1[11:10]), .alu_src_b(ow1[9:8]),
        .result_src(ow1[7:6]), .imm_src(ow1[5:4]), .alu_op(ow1[3:2]),
        .instr_done(ow1[1]), .illegal_op(ow1[0])
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [16:0] w;
        bit          br;
    } exp_t;
    exp_t q[$];

    typedef struct {
        string      name;
        logic [6:0] op;
        logic       zero;
        int         len;
        int         nreg;
        int         nmem;
        int         npc;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] mk(input bit pcw, input bit adr, input bit irw, input bit memw,
                                       input bit regw, input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] rs, input logic [1:0] alu, input bit done);
        return {pcw, adr, irw, memw, regw, sa, sb, rs, 2'b00, alu, done, 1'b0};
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        case (op)
            OP_SW:   return 2'b01;
            OP_BEQ:  return 2'b10;
            OP_JAL:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic push(input logic [16:0] w, input bit br);
        exp_t e;
        e.w  = w;
        e.br = br;
        q.push_back(e);
    endtask

    // Control-word schedule of one instruction, written as a microprogram table.
    task automatic build(input logic [6:0] op, input int fw);
        logic [16:0] aluwb;
        logic [16:0] memadr;
        aluwb  = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        memadr = mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0);
        for (int i = 0; i < fw; i++) push(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0), 0);
        push(mk(1, 0, 1, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0), 0);
        push(mk(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0), 0);
        case (op)
            OP_LW: begin
                push(memadr, 0);
                push(mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 0);
                push(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 2'b00, 1), 0);
            end
            OP_SW: begin
                push(memadr, 0);
                push(mk(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1), 0);
            end
            OP_R: begin
                push(mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10, 0), 0);
                push(aluwb, 0);
            end
            OP_I: begin
                push(mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b10, 0), 0);
                push(aluwb, 0);
            end
            OP_BEQ: push(mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 1), 1);
            OP_JAL: begin
                push(mk(1, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0), 0);
                push(aluwb, 0);
            end
            default: push(mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1), 0);
        endcase
    endtask

    task automatic run_instr(input logic [6:0] op, input logic z,
                             output int len, output int nreg, output int nmem, output int npc);
        op0 = op; z0 = z;
        len = 0; nreg = 0; nmem = 0; npc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            len++;
            if (ow0[12]) nreg++;
            if (ow0[13]) nmem++;
            if (ow0[16]) npc++;
            if (ow0[1]) begin
                tick();
                return;
            end
            tick();
        end
        len = -1;
    endtask

    logic [6:0]  ops [7];
    logic [6:0]  rop;
    logic [16:0] ew;
    exp_t        e;
    int          len, nreg, nmem, npc;

    initial begin
        ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_BAD};
        tbl.push_back('{"lw",     OP_LW,  1'b0, 5, 1, 0, 1});
        tbl.push_back('{"sw",     OP_SW,  1'b0, 4, 0, 1, 1});
        tbl.push_back('{"rtype",  OP_R,   1'b0, 4, 1, 0, 1});
        tbl.push_back('{"itype",  OP_I,   1'b0, 4, 1, 0, 1});
        tbl.push_back('{"beq_z1", OP_BEQ, 1'b1, 3, 0, 0, 2});
        tbl.push_back('{"beq_z0", OP_BEQ, 1'b0, 3, 0, 0, 1});
        tbl.push_back('{"jal",    OP_JAL, 1'b0, 4, 1, 0, 2});
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
        tbl.push_back('{"nop",    OP_BAD, 1'b1, 3, 0, 0, 1});
`endif
        rst0 = 1'b1; rst1 = 1'b1;
        op0 = OP_LW; op1 = OP_JAL;
        z0 = 1'b0;  z1 = 1'b0;
        #1;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_outputs", 32'(ow0), 32'd0);
            tick();
        end
        rst0 = 1'b0;
        @(negedge clk);
        check("first_fetch", 32'(ow0), 32'(mk(1, 0, 1, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0)));
        tick();
        rst0 = 1'b1; tick(); rst0 = 1'b0;

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].zero, len, nreg, nmem, npc);
            check({tbl[i].name, "_cycles"},    32'(len),  32'(tbl[i].len));
            check({tbl[i].name, "_regwrites"}, 32'(nreg), 32'(tbl[i].nreg));
            check({tbl[i].name, "_memwrites"}, 32'(nmem), 32'(tbl[i].nmem));
            check({tbl[i].name, "_pcwrites"},  32'(npc),  32'(tbl[i].npc));
        end

        // Abort a lw in MEMREAD: nothing may be written, restart at FETCH.
        op0 = OP_LW;
        tick(); tick(); tick();
        rst0 = 1'b1;
        @(negedge clk);
        check("abort_memread", 32'(ow0), 32'd0);
        tick();
        rst0 = 1'b0;
        @(negedge clk);
        check("fetch_after_abort", 32'(ow0), 32'(mk(1, 0, 1, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0)));
        tick();
        rst0 = 1'b1; tick(); rst0 = 1'b0;

        op0 = OP_BAD;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        tick(); tick();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("trap_hold", 32'({ow0[16], ow0[14:12], ow0[1], ow0[0]}), 32'b000001);
            tick();
        end
        rst0 = 1'b1; tick(); rst0 = 1'b0;
        @(negedge clk);
        check("trap_cleared", 32'(ow0), 32'(mk(1, 0, 1, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0)));
        tick();
        rst0 = 1'b1; tick(); rst0 = 1'b0;
`else
        tick();
        @(negedge clk);
        check("nop_decode_done", 32'(ow0[1]), 32'd0);
        tick();
        @(negedge clk);
        check("nop_final", 32'(ow0), 32'(mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1)));
        tick();
`endif

        for (int k = 0; k < 80; k++) begin
            rop = ops[$urandom_range(0, NOPS - 1)];
            build(rop, 0);
            op0 = rop;
            while (q.size() > 0) begin
                e  = q.pop_front();
                z0 = 1'($urandom_range(0, 1));
                ew = e.w | {11'b0, imm_of(rop), 4'b0};
                if (e.br) ew[16] = z0;
                @(negedge clk);
                check("random_cycle", 32'(ow0), 32'(ew));
                tick();
            end
        end

        // FETCH_WAIT = 3 instance: jal then sw.
        rst1 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rop = (k == 0) ? OP_JAL : OP_SW;
            build(rop, 3);
            op1 = rop;
            while (q.size() > 0) begin
                e  = q.pop_front();
                z1 = 1'($urandom_range(0, 1));
                ew = e.w | {11'b0, imm_of(rop), 4'b0};
                if (e.br) ew[16] = z1;
                @(negedge clk);
                check("fw3_cycle", 32'(ow1), 32'(ew));
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
